// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// EX-driven flush/hold handling and a saturating bubble counter.
module id_ex_stage_reg #(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [12:0]      id_ctrl,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic [RA_W-1:0]  id_rd,
  input  logic [3:0]       id_funct,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_flush_i,
  input  logic             ex_hold_i,
  output logic             ex_valid,
  output logic [12:0]      ex_ctrl,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [RA_W-1:0]  ex_rs1,
  output logic [RA_W-1:0]  ex_rs2,
  output logic [RA_W-1:0]  ex_rd,
  output logic [3:0]       ex_funct,
  output logic             id_stall_o,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Position of MemRead inside the control bundle.
  localparam int MEMREAD_BIT = 8;

  logic rs1_hit;
  logic rs2_hit;
  logic lu_haz;
  logic bubble;
  logic load_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  always_comb begin
    rs1_hit = id_uses_rs1 && (ex_rd == id_rs1);
    rs2_hit = id_uses_rs2 && (ex_rd == id_rs2);
    lu_haz  = ex_valid && ex_ctrl[MEMREAD_BIT] && (ex_rd != '0) && id_valid
              && (rs1_hit || rs2_hit);
    // Flush outranks everything; a hazard only bubbles when EX is not frozen.
    bubble  = ex_flush_i || (!ex_hold_i && lu_haz);
    load_en = !ex_flush_i && !ex_hold_i && !lu_haz;
  end

  // A flush lets IF refetch the target, so it cancels any stall request.
  assign id_stall_o = rst_n && (lu_haz || ex_hold_i) && !ex_flush_i;

  // Control stage: valid, control bundle and bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      bubble_cnt <= '0;
    end else begin
      if (bubble) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end else if (load_en) begin
        ex_valid <= id_valid;
        ex_ctrl  <= id_valid ? id_ctrl : 13'd0;
      end
      if (bubble && id_valid) begin
        bubble_cnt <= sat_inc(bubble_cnt);
      end
    end
  end

  // Datapath stage: only captured on a normal advance; bubbles keep old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct    <= '0;
    end else if (load_en) begin
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct    <= id_funct;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed instruction sequence with
// hand-chosen expected stall/bubble/count results, checked by a separate monitor.
module tb_id_ex_stage_reg;

  localparam logic [12:0] C_ALUI = 13'h1802;
  localparam logic [12:0] C_LW   = 13'h1B00;
  localparam logic [12:0] C_ADD  = 13'h1002;
  localparam logic [12:0] C_LUI  = 13'h1808;
  localparam logic [12:0] C_SW   = 13'h0C00;
  localparam int LD = 0, BUB = 1, HLD = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [12:0] id_ctrl;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_funct;
  logic        id_uses_rs1, id_uses_rs2, ex_flush_i, ex_hold_i;

  logic        ex_valid, id_stall_o;
  logic [12:0] ex_ctrl;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [3:0]  ex_funct;
  logic [15:0] bubble_cnt;

  logic        d2_valid, d2_stall;
  logic [12:0] d2_ctrl;
  logic [31:0] d2_pc, d2_rs1_data, d2_rs2_data, d2_imm;
  logic [4:0]  d2_rs1, d2_rs2, d2_rd;
  logic [3:0]  d2_funct;
  logic [1:0]  d2_cnt;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_flush_i(ex_flush_i), .ex_hold_i(ex_hold_i),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct(ex_funct), .id_stall_o(id_stall_o), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage_reg #(.XLEN(32), .RA_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ctrl(id_ctrl), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_flush_i(ex_flush_i), .ex_hold_i(ex_hold_i),
    .ex_valid(d2_valid), .ex_ctrl(d2_ctrl), .ex_pc(d2_pc), .ex_rs1_data(d2_rs1_data),
    .ex_rs2_data(d2_rs2_data), .ex_imm(d2_imm), .ex_rs1(d2_rs1), .ex_rs2(d2_rs2),
    .ex_rd(d2_rd), .ex_funct(d2_funct), .id_stall_o(d2_stall), .bubble_cnt(d2_cnt)
  );

  typedef struct {
    logic        vld;
    logic [12:0] ctrl;
    logic [31:0] pc, imm, r1d, r2d;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  funct;
  } ex_t;

  typedef struct {
    string nm;
    logic  stall;
    ex_t   st;
    int    cnt;
  } exp_t;

  exp_t q[$];
  ex_t  sh;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  task automatic ins(input bit v, input logic [12:0] c, input logic [31:0] pc,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input bit u1, input bit u2, input logic [31:0] imm);
    id_valid    = v;
    id_ctrl     = c;
    id_pc       = pc;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    id_imm      = imm;
    id_rs1_data = {pc[15:0], 16'h1111};
    id_rs2_data = {pc[15:0], 16'h2222};
    id_funct    = pc[5:2];
  endtask

  // Called right after inputs are driven at a negedge; describes the next posedge.
  task automatic step(input string nm, input bit stall, input int kind, input int cnt);
    exp_t e;
    if (kind == LD) begin
      sh.vld   = id_valid;
      sh.ctrl  = id_valid ? id_ctrl : 13'd0;
      sh.pc    = id_pc;
      sh.imm   = id_imm;
      sh.r1d   = id_rs1_data;
      sh.r2d   = id_rs2_data;
      sh.rs1   = id_rs1;
      sh.rs2   = id_rs2;
      sh.rd    = id_rd;
      sh.funct = id_funct;
    end else if (kind == BUB) begin
      sh.vld  = 1'b0;
      sh.ctrl = '0;
    end
    e.nm    = nm;
    e.stall = stall;
    e.st    = sh;
    e.cnt   = cnt;
    q.push_back(e);
  endtask

  // Monitor: stall is sampled before the edge, registers 1 time unit after it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk({e.nm, ".stall"}, {63'd0, id_stall_o}, {63'd0, e.stall});
        @(posedge clk);
        #1;
        chk({e.nm, ".valid"}, {63'd0, ex_valid}, {63'd0, e.st.vld});
        chk({e.nm, ".ctrl"}, {51'd0, ex_ctrl}, {51'd0, e.st.ctrl});
        chk({e.nm, ".pc"}, {32'd0, ex_pc}, {32'd0, e.st.pc});
        chk({e.nm, ".imm"}, {32'd0, ex_imm}, {32'd0, e.st.imm});
        chk({e.nm, ".data"}, {ex_rs1_data, ex_rs2_data}, {e.st.r1d, e.st.r2d});
        chk({e.nm, ".idx"}, {45'd0, ex_rs1, ex_rs2, ex_rd, ex_funct},
            {45'd0, e.st.rs1, e.st.rs2, e.st.rd, e.st.funct});
        chk({e.nm, ".cnt"}, {48'd0, bubble_cnt}, 64'(e.cnt));
        chk({e.nm, ".cnt_sat"}, {62'd0, d2_cnt}, 64'((e.cnt > 3) ? 3 : e.cnt));
      end
    end
  end

  task automatic drain();
    int i;
    i = 0;
    while (q.size() != 0 && i < 50) begin
      @(posedge clk);
      i++;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    sh = '{default: '0};
    rst_n = 1'b0;
    ex_flush_i = 1'b0;
    ex_hold_i = 1'b0;
    ins(0, 13'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ins(1'($urandom), 13'($urandom), $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
          1'($urandom), 1'($urandom), $urandom);
      ex_flush_i = 1'b0;
      ex_hold_i  = 1'b1;
      #2;
      chk("rst.valid", {63'd0, ex_valid}, 64'd0);
      chk("rst.stall", {63'd0, id_stall_o}, 64'd0);
      chk("rst.regs", {ex_ctrl, ex_pc, ex_rd, ex_rs1, ex_funct}, 64'd0);
      chk("rst.data", {ex_rs1_data | ex_rs2_data, ex_imm}, 64'd0);
      chk("rst.cnt", {46'd0, bubble_cnt, d2_cnt}, 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ex_hold_i = 1'b0;

    ins(1, C_ALUI, 32'h10, 5'd1, 5'd0, 5'd5, 1, 0, 32'd7);          step("addi", 0, LD, 0);
    @(negedge clk); ins(1, C_LW, 32'h14, 5'd5, 5'd0, 5'd6, 1, 0, 32'd4);   step("lw1", 0, LD, 0);
    @(negedge clk); ins(1, C_ADD, 32'h18, 5'd6, 5'd1, 5'd7, 1, 1, 32'd0);  step("lu_stall", 1, BUB, 1);
    @(negedge clk);                                                        step("lu_add", 0, LD, 1);
    @(negedge clk); ins(1, C_LW, 32'h1c, 5'd2, 5'd0, 5'd0, 1, 0, 32'd8);   step("lw_x0", 0, LD, 1);
    @(negedge clk); ins(1, C_ADD, 32'h20, 5'd0, 5'd1, 5'd7, 1, 1, 32'd0);  step("x0_nostall", 0, LD, 1);
    @(negedge clk); ins(1, C_LW, 32'h24, 5'd2, 5'd0, 5'd6, 1, 0, 32'hc);   step("lw2", 0, LD, 1);
    @(negedge clk); ins(1, C_LUI, 32'h28, 5'd6, 5'd6, 5'd6, 0, 0, 32'h12345000);
    step("lui_nostall", 0, LD, 1);
    @(negedge clk); ins(1, C_LW, 32'h2c, 5'd2, 5'd0, 5'd6, 1, 0, 32'd0);   step("lw3", 0, LD, 1);
    @(negedge clk); ins(1, C_SW, 32'h30, 5'd2, 5'd6, 5'd0, 1, 1, 32'd0);   step("sw_stall", 1, BUB, 2);
    @(negedge clk);                                                        step("sw_go", 0, LD, 2);
    @(negedge clk); ins(1, C_LW, 32'h34, 5'd2, 5'd0, 5'd6, 1, 0, 32'd0);   step("lw4", 0, LD, 2);
    @(negedge clk); ins(1, C_ADD, 32'h38, 5'd6, 5'd1, 5'd7, 1, 1, 32'd0);
    ex_flush_i = 1'b1;                                                     step("flush_haz", 0, BUB, 3);
    @(negedge clk); ex_flush_i = 1'b0;
    ins(1, C_ALUI, 32'h80, 5'd0, 5'd0, 5'd5, 1, 0, 32'd1);                 step("target", 0, LD, 3);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); ex_hold_i = 1'b1;
      ins(1, C_LW, 32'h84, 5'd5, 5'd0, 5'd9, 1, 0, 32'd0);                 step("hold", 1, HLD, 3);
    end
    @(negedge clk); ex_hold_i = 1'b0;                                      step("unhold", 0, LD, 3);
    @(negedge clk); ex_flush_i = 1'b1; ex_hold_i = 1'b1;
    ins(1, C_ALUI, 32'h88, 5'd0, 5'd0, 5'd5, 1, 0, 32'd2);                 step("flush_hold", 0, BUB, 4);
    @(negedge clk); ex_flush_i = 1'b0; ex_hold_i = 1'b0;
    ins(0, C_ALUI, 32'h8c, 5'd3, 5'd4, 5'd5, 1, 0, 32'd3);                 step("invalid", 0, LD, 4);
    @(negedge clk); ex_flush_i = 1'b1;
    ins(0, C_ALUI, 32'h90, 5'd3, 5'd4, 5'd5, 1, 0, 32'd3);                 step("flush_inv", 0, BUB, 4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      ins(1, C_ALUI, 32'h94, 5'd1, 5'd0, 5'd5, 1, 0, 32'd5);               step("sat", 0, BUB, 4 + k);
    end
    @(negedge clk); ex_flush_i = 1'b0;
    ins(0, 13'd0, 32'd0, 5'd0, 5'd0, 5'd0, 0, 0, 32'd0);
    drain();

    // Reset asserted mid-cycle while ID holds a valid instruction and EX is frozen.
    ins(1, C_ALUI, 32'hA0, 5'd1, 5'd0, 5'd5, 1, 0, 32'd9);
    ex_hold_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst.valid", {63'd0, ex_valid}, 64'd0);
    chk("midrst.stall", {63'd0, id_stall_o}, 64'd0);
    chk("midrst.regs", {ex_ctrl, ex_pc, ex_rd, ex_rs1, ex_funct}, 64'd0);
    chk("midrst.cnt", {46'd0, bubble_cnt, d2_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ex_hold_i = 1'b0;
    sh = '{default: '0};
    step("post_rst", 0, LD, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation time exceeded, expected completion");
    $fatal(1, "timeout");
  end

endmodule
